// File: rtl/keypad_tok_pkg.sv
// Shared keypad token definitions used by the token transmitter and the
// decoded-keypad receiver.
package keypad_tok_pkg;

  typedef logic [3:0] tok_t;

  localparam tok_t SPACE    = 4'd10;
  localparam tok_t ENTER    = 4'd11;
  localparam tok_t FORWARD  = 4'd12;
  localparam tok_t BACKWARD = 4'd13;
  localparam tok_t INVALID  = 4'd14;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONV   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_GAP    = 3'd4
  } tx_state_t;

  // A command is legal for motors 1..4 with an angle no larger than max_angle.
  function automatic logic cmd_legal(input logic [2:0] motor,
                                     input logic [8:0] angle,
                                     input logic [8:0] max_angle);
    return (motor >= 3'd1) && (motor <= 3'd4) && (angle <= max_angle);
  endfunction

endpackage

// File: rtl/cmd_token_tx_if.sv
// Command handshake and keypad token bus of the command-to-token transmitter.
interface cmd_token_tx_if;
  import keypad_tok_pkg::*;

  logic       i_cmd_valid;
  logic       o_cmd_ready;
  logic [2:0] i_motor;
  logic       i_dir;
  logic [8:0] i_angle;
  tok_t       o_data_dec;
  logic       o_ena;
  logic       o_busy;
  logic       o_err;

  modport master (
    output i_cmd_valid, i_motor, i_dir, i_angle,
    input  o_cmd_ready, o_data_dec, o_ena, o_busy, o_err
  );

  modport slave (
    input  i_cmd_valid, i_motor, i_dir, i_angle,
    output o_cmd_ready, o_data_dec, o_ena, o_busy, o_err
  );

endinterface

// File: rtl/cmd_token_tx_bin2bcd_seq.sv
// Sequential binary-to-BCD converter: repeated subtraction of 100 then 10,
// one subtraction per cycle; done is raised once the remainder is one digit.
module bin2bcd_seq
  import keypad_tok_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [8:0] bin,
  output logic       done,
  output tok_t       bcd_h,
  output tok_t       bcd_t,
  output tok_t       bcd_u,
  output logic [1:0] n_digits
);

  logic [8:0] rem_r;
  logic [3:0] h_r;
  logic [3:0] t_r;
  logic       run_r;

  // remainder / digit counters, one subtraction step per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_r <= 9'd0;
      h_r   <= 4'd0;
      t_r   <= 4'd0;
      run_r <= 1'b0;
    end else if (start) begin
      rem_r <= bin;
      h_r   <= 4'd0;
      t_r   <= 4'd0;
      run_r <= 1'b1;
    end else if (run_r) begin
      if (rem_r >= 9'd100) begin
        rem_r <= rem_r - 9'd100;
        h_r   <= h_r + 4'd1;
      end else if (rem_r >= 9'd10) begin
        rem_r <= rem_r - 9'd10;
        t_r   <= t_r + 4'd1;
      end else begin
        run_r <= 1'b0;
      end
    end else begin
      run_r <= 1'b0;
    end
  end

  assign done  = run_r && (rem_r < 9'd10);
  assign bcd_h = h_r;
  assign bcd_t = t_r;
  assign bcd_u = rem_r[3:0];

  // significant digit count with leading zeros suppressed
  always_comb begin
    n_digits = 2'd1;
    if (h_r != 4'd0) begin
      n_digits = 2'd3;
    end else if (t_r != 4'd0) begin
      n_digits = 2'd2;
    end else begin
      n_digits = 2'd1;
    end
  end

endmodule

// File: rtl/cmd_token_tx.sv
// Serialises one motor command as <motor> SPACE <dir> <digits> ENTER on the
// decoded-keypad token bus, with setup / strobe / gap timing per token.
module cmd_token_tx
  import keypad_tok_pkg::*;
#(
  parameter int SETUP_CYC = 2,
  parameter int ENA_CYC   = 1,
  parameter int GAP_CYC   = 4,
  parameter int MAX_ANGLE = 359
) (
  input  logic           in_Clk,
  input  logic           in_Rst,
  cmd_token_tx_if.slave  bus
);

  localparam int CNT_MAX = (SETUP_CYC > ENA_CYC)
                         ? ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC)
                         : ((ENA_CYC > GAP_CYC) ? ENA_CYC : GAP_CYC);
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] ENA_LAST   = CNT_W'(ENA_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
  localparam logic [8:0]       MAX_ANG9   = 9'(MAX_ANGLE);

  if ((SETUP_CYC < 1) || (ENA_CYC < 1) || (GAP_CYC < 1)) begin : g_param_chk
    $error("cmd_token_tx: SETUP_CYC, ENA_CYC and GAP_CYC must all be >= 1");
  end

  tx_state_t        state_r, state_s;
  logic [CNT_W-1:0] cnt_r;
  tok_t             tok_r [8];
  tok_t             tok_list_s [8];
  logic [2:0]       len_r, len_s;
  logic [2:0]       idx_r;
  logic [2:0]       motor_r;
  logic             dir_r;
  tok_t             data_r;
  logic             ena_r, busy_r, ready_r, err_r;

  logic             accept_s, legal_s, start_s;
  logic             conv_done_s;
  tok_t             bcd_h_s, bcd_t_s, bcd_u_s;
  logic [1:0]       n_digits_s;

  assign accept_s = bus.i_cmd_valid && ready_r;
  assign legal_s  = cmd_legal(bus.i_motor, bus.i_angle, MAX_ANG9);
  assign start_s  = accept_s && legal_s;

  bin2bcd_seq u_bcd (
    .clk      (in_Clk),
    .rst      (in_Rst),
    .start    (start_s),
    .bin      (bus.i_angle),
    .done     (conv_done_s),
    .bcd_h    (bcd_h_s),
    .bcd_t    (bcd_t_s),
    .bcd_u    (bcd_u_s),
    .n_digits (n_digits_s)
  );

  // frame token list assembled from the captured command and converted digits
  always_comb begin
    for (int i = 0; i < 8; i++) tok_list_s[i] = INVALID;
    tok_list_s[0] = {1'b0, motor_r};
    tok_list_s[1] = SPACE;
    if (dir_r) tok_list_s[2] = BACKWARD;
    else       tok_list_s[2] = FORWARD;
    len_s = 3'd5;
    case (n_digits_s)
      2'd3: begin
        tok_list_s[3] = bcd_h_s;
        tok_list_s[4] = bcd_t_s;
        tok_list_s[5] = bcd_u_s;
        tok_list_s[6] = ENTER;
        len_s         = 3'd7;
      end
      2'd2: begin
        tok_list_s[3] = bcd_t_s;
        tok_list_s[4] = bcd_u_s;
        tok_list_s[5] = ENTER;
        len_s         = 3'd6;
      end
      default: begin
        tok_list_s[3] = bcd_u_s;
        tok_list_s[4] = ENTER;
        len_s         = 3'd5;
      end
    endcase
  end

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:   if (start_s) state_s = ST_CONV; else state_s = ST_IDLE;
      ST_CONV:   if (conv_done_s) state_s = ST_SETUP; else state_s = ST_CONV;
      ST_SETUP:  if (cnt_r == SETUP_LAST) state_s = ST_STROBE; else state_s = ST_SETUP;
      ST_STROBE: if (cnt_r == ENA_LAST) state_s = ST_GAP; else state_s = ST_STROBE;
      ST_GAP: begin
        if (cnt_r == GAP_LAST) begin
          if (idx_r == (len_r - 3'd1)) state_s = ST_IDLE;
          else                         state_s = ST_SETUP;
        end else begin
          state_s = ST_GAP;
        end
      end
      default:   state_s = ST_IDLE;
    endcase
  end

  // state, timing counter, token store and registered outputs
  always_ff @(posedge in_Clk) begin
    if (in_Rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      for (int i = 0; i < 8; i++) tok_r[i] <= INVALID;
      len_r   <= 3'd0;
      idx_r   <= 3'd0;
      motor_r <= 3'd0;
      dir_r   <= 1'b0;
      data_r  <= 4'd0;
      ena_r   <= 1'b0;
      busy_r  <= 1'b0;
      ready_r <= 1'b1;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      ready_r <= (state_s == ST_IDLE);
      busy_r  <= (state_s != ST_IDLE);
      ena_r   <= (state_s == ST_STROBE);
      err_r   <= accept_s && !legal_s;
      if ((state_s != state_r) || (state_r == ST_IDLE) || (state_r == ST_CONV)) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (start_s) begin
        motor_r <= bus.i_motor;
        dir_r   <= bus.i_dir;
      end
      // data changes only on SETUP entry, so it stays stable through STROBE and GAP
      if ((state_r == ST_CONV) && conv_done_s) begin
        tok_r  <= tok_list_s;
        len_r  <= len_s;
        idx_r  <= 3'd0;
        data_r <= tok_list_s[0];
      end else if ((state_r == ST_GAP) && (state_s == ST_SETUP)) begin
        idx_r  <= idx_r + 3'd1;
        data_r <= tok_r[idx_r + 3'd1];
      end
    end
  end

  assign bus.o_data_dec  = data_r;
  assign bus.o_ena       = ena_r;
  assign bus.o_busy      = busy_r;
  assign bus.o_cmd_ready = ready_r;
  assign bus.o_err       = err_r;

endmodule

// File: tb/tb_cmd_token_tx.sv
// Randomised and directed bench for cmd_token_tx against a cycle-level
// expected-output queue built from the frame rules.
module tb_cmd_token_tx;
  import keypad_tok_pkg::*;

  localparam int T_SETUP = 2;
  localparam int T_ENA   = 1;
  localparam int T_GAP   = 4;

  typedef struct {
    logic [3:0] data;
    logic       ena;
    logic       busy;
    logic       ready;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  cmd_token_tx_if bus ();

  cmd_token_tx dut (
    .in_Clk (clk),
    .in_Rst (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t q[$];
  exp_t cur = '{4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
  bit   model_on = 1'b0;
  logic [3:0] last_data = 4'd0;
  int   model_toks[$];
  int   pulses[$];
  int   pulse_cyc[$];
  int   err_seen = 0;

  task automatic chk_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input int m, input int a);
    return (m >= 1) && (m <= 4) && (a <= 359);
  endfunction

  function automatic void make_tokens(input int m, input bit d, input int a);
    model_toks.delete();
    model_toks.push_back(m);
    model_toks.push_back(10);
    model_toks.push_back(d ? 13 : 12);
    if (a >= 100) model_toks.push_back(a / 100);
    if (a >= 10)  model_toks.push_back((a / 10) % 10);
    model_toks.push_back(a % 10);
    model_toks.push_back(11);
  endfunction

  // reference model: expected outputs for the cycle following each edge
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      last_data = 4'd0;
      cur       = '{4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
      model_on  = 1'b1;
    end else if (model_on) begin
      if (cur.ready && (bus.i_cmd_valid === 1'b1)) begin
        int m, a;
        m = int'(bus.i_motor);
        a = int'(bus.i_angle);
        if (!is_legal(m, a)) begin
          q.push_back('{last_data, 1'b0, 1'b0, 1'b1, 1'b1});
        end else begin
          int n_conv;
          n_conv = (a / 100) + ((a % 100) / 10) + 1;
          for (int i = 0; i < n_conv; i++) q.push_back('{last_data, 1'b0, 1'b1, 1'b0, 1'b0});
          make_tokens(m, bus.i_dir, a);
          foreach (model_toks[k]) begin
            logic [3:0] tk;
            tk = 4'(model_toks[k]);
            for (int i = 0; i < T_SETUP; i++) q.push_back('{tk, 1'b0, 1'b1, 1'b0, 1'b0});
            for (int i = 0; i < T_ENA; i++)   q.push_back('{tk, 1'b1, 1'b1, 1'b0, 1'b0});
            for (int i = 0; i < T_GAP; i++)   q.push_back('{tk, 1'b0, 1'b1, 1'b0, 1'b0});
          end
          last_data = 4'd11;
        end
      end
      if (q.size() > 0) cur = q.pop_front();
      else              cur = '{last_data, 1'b0, 1'b0, 1'b1, 1'b0};
    end
  end

  // per-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (model_on) begin
      logic [7:0] act, exp;
      act = {bus.o_data_dec, bus.o_ena, bus.o_busy, bus.o_cmd_ready, bus.o_err};
      exp = {cur.data, cur.ena, cur.busy, cur.ready, cur.err};
      n_tests++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL cycle_outputs {data,ena,busy,ready,err}: got %h, expected %h (cycle %0d)",
                 act, exp, cyc);
      end
    end
  end

  // strobe and error recorder for the directed checks
  always @(negedge clk) begin
    if (bus.o_ena === 1'b1) begin
      pulses.push_back(int'(bus.o_data_dec));
      pulse_cyc.push_back(cyc);
    end
    if (bus.o_err === 1'b1) err_seen++;
  end

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (!cur.ready && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    if (!cur.ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: still busy after %0d cycles", budget);
    end
  endtask

  task automatic send(input int m, input bit d, input int a);
    wait_ready(300);
    bus.i_motor     = 3'(m);
    bus.i_dir       = d;
    bus.i_angle     = 9'(a);
    bus.i_cmd_valid = 1'b1;
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
  endtask

  task automatic clear_rec();
    pulses.delete();
    pulse_cyc.delete();
    err_seen = 0;
  endtask

  task automatic check_pulses(input string name, input int exp[7], input int n);
    chk_int({name, "_count"}, pulses.size(), n);
    for (int i = 0; (i < n) && (i < pulses.size()); i++) chk_int({name, "_token"}, pulses[i], exp[i]);
    for (int i = 1; i < pulse_cyc.size(); i++)
      chk_int({name, "_period"}, pulse_cyc[i] - pulse_cyc[i-1], 7);
  endtask

  task automatic run_frame(input string name, input int m, input bit d, input int a,
                           input int exp[7], input int n);
    clear_rec();
    send(m, d, a);
    wait_ready(300);
    repeat (2) @(negedge clk);
    check_pulses(name, exp, n);
  endtask

  task automatic run_reject(input string name, input int m, input int a);
    clear_rec();
    send(m, 1'b0, a);
    repeat (8) @(negedge clk);
    chk_int({name, "_pulses"}, pulses.size(), 0);
    chk_int({name, "_err_cycles"}, err_seen, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, seen;
    bus.i_cmd_valid = 1'b0;
    bus.i_motor     = 3'd0;
    bus.i_dir       = 1'b0;
    bus.i_angle     = 9'd0;

    // pin the token model against hand-written frames
    make_tokens(3, 1'b1, 210);
    chk_int("model_len_210", model_toks.size(), 7);
    chk_int("model_tok3_210", model_toks[3], 2);
    chk_int("model_tok5_210", model_toks[5], 0);
    make_tokens(1, 1'b1, 0);
    chk_int("model_len_0", model_toks.size(), 5);
    chk_int("model_tok2_0", model_toks[2], 13);

    repeat (3) @(negedge clk);
    chk_int("reset_outputs",
            int'({bus.o_data_dec, bus.o_ena, bus.o_busy, bus.o_cmd_ready, bus.o_err}), 8'h02);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_frame("m2_fwd_128", 2, 1'b0, 128, '{2, 10, 12, 1, 2, 8, 11}, 7);
    run_frame("m3_bwd_210", 3, 1'b1, 210, '{3, 10, 13, 2, 1, 0, 11}, 7);
    run_frame("m4_fwd_7",   4, 1'b0, 7,   '{4, 10, 12, 7, 11, 0, 0}, 5);
    run_frame("m1_bwd_0",   1, 1'b1, 0,   '{1, 10, 13, 0, 11, 0, 0}, 5);
    run_frame("m1_fwd_359", 1, 1'b0, 359, '{1, 10, 12, 3, 5, 9, 11}, 7);

    run_reject("rej_motor5", 5, 90);
    run_reject("rej_motor0", 0, 90);
    run_reject("rej_angle360", 1, 360);

    // second command held valid during a frame is dropped
    clear_rec();
    wait_ready(300);
    bus.i_motor = 3'd2; bus.i_dir = 1'b0; bus.i_angle = 9'd128; bus.i_cmd_valid = 1'b1;
    @(negedge clk);
    bus.i_motor = 3'd3; bus.i_dir = 1'b1; bus.i_angle = 9'd210;
    repeat (20) @(negedge clk);
    bus.i_cmd_valid = 1'b0;
    wait_ready(300);
    repeat (2) @(negedge clk);
    check_pulses("held_valid", '{2, 10, 12, 1, 2, 8, 11}, 7);
    run_frame("after_held", 3, 1'b1, 210, '{3, 10, 13, 2, 1, 0, 11}, 7);

    // reset during the 4th strobe abandons the frame
    clear_rec();
    send(2, 1'b0, 128);
    n = 0; seen = 0;
    while ((seen < 4) && (n < 300)) begin
      @(negedge clk);
      n++;
      if (bus.o_ena === 1'b1) seen++;
    end
    chk_int("rst_reach_4th_strobe", seen, 4);
    rst = 1'b1;
    @(negedge clk);
    chk_int("rst_ena_low", int'(bus.o_ena), 0);
    chk_int("rst_busy_low", int'(bus.o_busy), 0);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check_pulses("rst_mid_frame", '{2, 10, 12, 1, 0, 0, 0}, 4);
    run_frame("after_rst", 2, 1'b0, 128, '{2, 10, 12, 1, 2, 8, 11}, 7);

    // random commands, mostly legal, checked cycle by cycle
    for (int k = 0; k < 40; k++) begin
      int m, a;
      bit d;
      if ($urandom_range(0, 3) != 0) begin
        m = $urandom_range(1, 4);
        a = $urandom_range(0, 359);
      end else begin
        m = $urandom_range(0, 7);
        a = $urandom_range(300, 511);
      end
      d = 1'($urandom_range(0, 1));
      send(m, d, a);
      wait_ready(300);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
